// File: rtl/encoder_8_3_queued.sv
// Captures up to 8 one-bit request lines and presents them one at a time as a 3-bit index over valid/ready.
// Define ROUND_ROBIN_EN for rotating priority; the default build uses fixed priority with bit 7 highest.
module encoder_8_3_queued #(
    parameter logic [7:0] REQ_MASK = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       en,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] out_idx,
    output logic [7:0] pending
);

    // Handshake: a transfer happens on a rising edge where out_valid and out_ready are both 1.
    // Once out_valid is high, out_idx is held stable until that transfer (no preemption).
    // out_ready is ignored while out_valid is low.

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_nxt;
    logic [7:0] pending_q;
    logic [7:0] pending_nxt;
    logic [7:0] set_v;
    logic [7:0] clr_v;
    logic [2:0] idx_q;
    logic [2:0] idx_nxt;
    logic [2:0] sel_idx;
    logic [2:0] sel_j;
    logic [2:0] last_cur;
    logic       accept;

    assign accept = (state_q == HOLD) && out_ready;
    assign clr_v  = accept ? (8'd1 << idx_q) : 8'd0;
    assign set_v  = req & REQ_MASK & {8{en}};

    // A new event on the bit being accepted re-queues it, so set is applied after clr.
    assign pending_nxt = (pending_q & ~clr_v) | set_v;

`ifdef ROUND_ROBIN_EN
    logic [2:0] last_q;

    // The index accepted this cycle already counts as served for the next selection.
    assign last_cur = accept ? idx_q : last_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= 3'd0;
        end else begin
            last_q <= last_cur;
        end
    end
`else
    assign last_cur = 3'd0;
`endif

    // Search (last-1) down to last; later matches overwrite earlier, so the nearest wins.
    always_comb begin
        sel_idx = 3'd0;
        sel_j   = 3'd0;
        for (int i = 8; i >= 1; i--) begin
            sel_j = last_cur - 3'(i);
            if (pending_nxt[sel_j]) begin
                sel_idx = sel_j;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        case (state_q)
            IDLE: begin
                if (|pending_nxt) begin
                    state_nxt = HOLD;
                    idx_nxt   = sel_idx;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (|pending_nxt) begin
                        idx_nxt = sel_idx;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 8'd0;
            idx_q     <= 3'd0;
        end else begin
            state_q   <= state_nxt;
            pending_q <= pending_nxt;
            idx_q     <= idx_nxt;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_idx   = idx_q;
    assign pending   = pending_q;

endmodule
